// File: rtl/restoring_div_32.sv
// restoring_div_32: signed 32-bit restoring divider, one quotient bit per cycle, divide-by-zero flag
module restoring_div_32 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        sign_q;
  logic        dz;
  logic        start;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] shifted;
  logic [32:0] diff;
  always_comb begin
    start   = ctrl_DIV && (state != BUSY);
    abs_a   = data_operandA[31] ? ~data_operandA + 32'd1 : data_operandA;
    abs_b   = data_operandB[31] ? ~data_operandB + 32'd1 : data_operandB;
    shifted = {rem[31:0], quo[31]};
    diff    = shifted + {1'b1, ~dvs} + 33'd1;
  end
  // quo starts as |A| and is shifted out MSB-first while quotient bits shift in at the LSB
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      rem            <= '0;
      quo            <= '0;
      dvs            <= '0;
      sign_q         <= 1'b0;
      dz             <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= state == DONE;
      data_exception <= state == DONE && dz;
      if (state == DONE)
        data_result <= dz ? '0 : (sign_q ? ~quo + 32'd1 : quo);
      if (start) begin
        sign_q <= data_operandA[31] ^ data_operandB[31];
        quo    <= abs_a;
        dvs    <= abs_b;
        rem    <= '0;
        cnt    <= '0;
        dz     <= data_operandB == '0;
        state  <= data_operandB == '0 ? DONE : BUSY;
      end else if (state == BUSY) begin
        rem   <= diff[32] ? shifted : diff;
        quo   <= {quo[30:0], ~diff[32]};
        cnt   <= cnt + 5'd1;
        state <= cnt == 5'd31 ? DONE : BUSY;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_restoring_div_32.sv
// tb_restoring_div_32: directed checks of latency, signed quotients, divide-by-zero, overlap, reset abort
module tb_restoring_div_32;
  logic        clock;
  logic        reset_n;
  logic        ctrl_DIV;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  int          errors;
  int          checks;

  restoring_div_32 dut (
    .clock(clock),
    .reset_n(reset_n),
    .ctrl_DIV(ctrl_DIV),
    .data_operandA(a),
    .data_operandB(b),
    .data_result(data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // n counts clock edges since the acceptance edge; bounded so a dead DUT cannot hang the run
  task automatic wait_rdy(input int n0, output int n);
    n = n0;
    while (!data_resultRDY && n < 100) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic run(input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] exp_r,
                     input logic exp_e, input int exp_n, input string tag);
    int n;
    ctrl_DIV = 1'b1;
    a = ra;
    b = rb;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    wait_rdy(0, n);
    chk({tag, "_lat"}, 32'(n), 32'(exp_n));
    chk({tag, "_res"}, data_result, exp_r);
    chk({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_e});
    @(negedge clock);
    chk({tag, "_pulse"}, {31'd0, data_resultRDY}, 32'd0);
    chk({tag, "_hold"}, data_result, exp_r);
  endtask

  initial begin
    int n;
    int pulses;
    errors   = 0;
    checks   = 0;
    reset_n  = 1'b0;
    ctrl_DIV = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(negedge clock);
    chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("rst_exc", {31'd0, data_exception}, 32'd0);
    chk("rst_res", data_result, 32'd0);
    reset_n = 1'b1;
    run(32'd100, 32'd7, 32'h0000000E, 1'b0, 33, "p100_7");
    run(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0, 33, "m100_7");
    run(32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, 1'b0, 33, "m100_m7");
    run(32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 33, "p100_m7");
    run(32'd7, 32'd100, 32'd0, 1'b0, 33, "p7_100");
    run(32'd5, 32'd0, 32'd0, 1'b1, 1, "div0");
    run(32'd9, 32'd3, 32'd3, 1'b0, 33, "p9_3");
    run(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33, "min_m1");
    run(32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 1'b0, 33, "max_1");
    run(32'h80000000, 32'd2, 32'hC0000000, 1'b0, 33, "min_2");
    run(32'h80000000, 32'd1, 32'h80000000, 1'b0, 33, "min_1");
    run(32'd0, 32'd5, 32'd0, 1'b0, 33, "zero_5");

    // a start request and operand changes during BUSY must not disturb the running division
    ctrl_DIV = 1'b1;
    a = 32'd100;
    b = 32'd7;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (10) @(negedge clock);
    ctrl_DIV = 1'b1;
    a = 32'd50;
    b = 32'd5;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    a = $urandom;
    b = 32'd0;
    wait_rdy(11, n);
    chk("ovl_lat", 32'(n), 32'd33);
    chk("ovl_res", data_result, 32'h0000000E);
    chk("ovl_exc", {31'd0, data_exception}, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    chk("ovl_no_second", 32'(pulses), 32'd0);

    // reset asserted mid-BUSY clears outputs at once and the aborted operation never completes
    ctrl_DIV = 1'b1;
    a = 32'd100;
    b = 32'd7;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (15) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("abort_res", data_result, 32'd0);
    chk("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("abort_exc", {31'd0, data_exception}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    chk("abort_no_rdy", 32'(pulses), 32'd0);
    run(32'd20, 32'd4, 32'd5, 1'b0, 33, "p20_4");

    // a start in the DONE cycle is accepted back-to-back while the previous result pulses
    ctrl_DIV = 1'b1;
    a = 32'd100;
    b = 32'd7;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (32) @(negedge clock);
    chk("b2b_pre", {31'd0, data_resultRDY}, 32'd0);
    ctrl_DIV = 1'b1;
    a = 32'd6;
    b = 32'd2;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    chk("b2b_first_rdy", {31'd0, data_resultRDY}, 32'd1);
    chk("b2b_first_res", data_result, 32'h0000000E);
    @(negedge clock);
    wait_rdy(1, n);
    chk("b2b_lat", 32'(n), 32'd33);
    chk("b2b_res", data_result, 32'd3);
    chk("b2b_exc", {31'd0, data_exception}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/restoring_div_32.md
RESTORING_DIV_32 -- requirements
Module: restoring_div_32

Interface
REQ-001 SHALL: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: reset_n  input  1  asynchronous, active-low reset; one clock, no other reset source.
REQ-003 SHALL: ctrl_DIV  input  1  start request; sampled on rising edge of clock.
REQ-004 SHALL: data_operandA  input  32  signed two's-complement dividend.
REQ-005 SHALL: data_operandB  input  32  signed two's-complement divisor.
REQ-006 SHALL: data_result  output  32  signed quotient, truncated toward zero.
REQ-007 SHALL: data_exception  output  1  divide-by-zero flag; valid only while data_resultRDY=1.
REQ-008 SHALL: data_resultRDY  output  1  one-cycle completion pulse.

Function
REQ-009 SHALL: FSM states IDLE, BUSY, DONE; encoding free.
REQ-010 SHALL: start is accepted when ctrl_DIV=1 at an edge while state is IDLE or DONE. If operandB != 0, go to BUSY. If operandB = 0, go to DONE with the exception path.
REQ-011 SHALL: at acceptance, latch sign_q = A[31] XOR B[31], |A| and |B| as 32-bit unsigned magnitudes, clear the 33-bit partial remainder, and load iteration counter = 0.
REQ-012 SHALL: operand changes after acceptance have no effect on the current operation.
REQ-013 SHALL: ctrl_DIV while BUSY is ignored; no queuing.
REQ-014 SHALL: each BUSY cycle performs one restoring step:
- shift {remainder, quotient} left 1, bringing the next dividend MSB into the remainder LSB;
- compute remainder - |B| as remainder + ~|B| + 1 (33-bit);
- if the result is non-negative, commit it and set quotient LSB = 1; otherwise keep the remainder and set quotient LSB = 0.
REQ-015 SHALL: BUSY lasts exactly 32 cycles (counter 0..31). After the 32nd step, enter DONE.
REQ-016 SHALL: in DONE, assert data_resultRDY=1 for exactly one cycle. Leave DONE on the next edge, to BUSY if a new start is accepted, else to IDLE.
REQ-017 SHALL: latency for nonzero divisor: accepted at edge k, data_resultRDY high in the cycle following edge k+33.
REQ-018 SHALL: data_result = sign_q ? (~quotient + 1) : quotient, registered, and held stable from DONE until the edge following the next acceptance.
REQ-019 SHALL: for divisor 0: data_resultRDY high in the cycle following edge k+1, with data_exception=1 and data_result=0.
REQ-020 SHALL: data_exception=0 for every nonzero divisor, and is cleared on the next acceptance.
REQ-021 SHALL: 0x80000000 / 0xFFFFFFFF yields data_result=0x80000000 (two's-complement wrap), data_exception=0.
REQ-022 SHALL: dividend 0 with nonzero divisor yields 0 after the full 33-cycle latency; no early termination.
REQ-023 SHALL: |0x80000000| is treated as unsigned 0x80000000.

Reset
REQ-024 SHALL: reset_n=0 immediately forces state=IDLE, data_resultRDY=0, data_exception=0, data_result=0, counter=0, and remainder/quotient registers=0.
REQ-025 SHALL: reset asserted mid-BUSY aborts the operation; no data_resultRDY pulse is produced for it.
REQ-026 SHALL: the first start is accepted at the first rising edge after reset_n deasserts.

Verification
REQ-027 SHALL: A=100, B=7, ctrl_DIV pulse -> data_resultRDY exactly 33 cycles after the acceptance edge, data_result=0x0000000E, data_exception=0.
REQ-028 SHALL: A=-100 (0xFFFFFF9C), B=7 -> data_result=0xFFFFFFF2; A=-100, B=-7 -> 0x0000000E; A=7, B=100 -> 0.
REQ-029 SHALL: A=5, B=0 -> data_resultRDY one cycle after acceptance, data_exception=1, data_result=0; a following 9/3 gives 3 with data_exception=0.
REQ-030 SHALL: A=0x80000000, B=0xFFFFFFFF -> 0x80000000, data_exception=0; A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF.
REQ-031 SHALL: start 100/7, pulse ctrl_DIV with 50/5 at cycle 10 and change operands mid-BUSY -> single result 0x0000000E at cycle 33, no second pulse.
REQ-032 SHALL: reset_n low at cycle 15 of BUSY -> all outputs 0 immediately, no data_resultRDY; restart 20/4 -> 0x00000005 after 33 cycles. Also start 6/2 in the DONE cycle -> back-to-back accepted, result 3 after 33 cycles.
